// File: rtl/lsp_pkg.sv
// Shared configuration and record types for the load/store unit.
// All widths and depths are set here, so every file agrees on the struct layouts.
package lsp_pkg;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 16;
    localparam int TAG_W    = 6;
    localparam int SB_DEPTH = 8;
    localparam int MEM_LAT  = 2;
    localparam int COMMIT_W = 2;

    localparam int IDX_W = $clog2(SB_DEPTH);
    // The extra pointer bit tells a full queue apart from an empty one.
    localparam int PTR_W = IDX_W + 1;
    localparam int CMT_W = $clog2(COMMIT_W + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic              hit;
        logic [DATA_W-1:0] data;
    } ld_stage_t;
endpackage

// File: rtl/load_store_pipe_sb_search_queue.sv
// Store queue: circular buffer with head/commit/tail pointers, drain port
// and a youngest-match address search for load forwarding.
module sb_search_queue
    import lsp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              st_push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic [CMT_W-1:0]  commit_req,
    input  logic [ADDR_W-1:0] search_addr,
    output logic              search_hit,
    output logic [DATA_W-1:0] search_data,
    output logic              full,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready
);
    logic [PTR_W-1:0] head_reg, cptr_reg, tail_reg;
    logic [PTR_W-1:0] count, uncommitted, req_ext, commit_n, cptr_next;
    logic             drain;
    sb_entry_t        entries [SB_DEPTH];

    assign count       = tail_reg - head_reg;
    assign uncommitted = tail_reg - cptr_reg;
    assign req_ext     = PTR_W'(commit_req);
    assign commit_n    = (req_ext > uncommitted) ? uncommitted : req_ext;
    assign cptr_next   = cptr_reg + commit_n;
    assign full        = (count == PTR_W'(SB_DEPTH));

    // Full-pointer compare also covers the case of every entry committed.
    assign wr_valid = (head_reg != cptr_reg);
    assign drain    = wr_valid && wr_ready;
    assign wr_addr  = wr_valid ? entries[head_reg[IDX_W-1:0]].addr : '0;
    assign wr_data  = wr_valid ? entries[head_reg[IDX_W-1:0]].data : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg <= '0;
            cptr_reg <= '0;
            tail_reg <= '0;
        end else begin
            head_reg <= head_reg + PTR_W'(drain);
            cptr_reg <= cptr_next;
            tail_reg <= flush ? cptr_next : tail_reg + PTR_W'(st_push);
        end
    end

    always_ff @(posedge clk) begin
        if (st_push) begin
            entries[tail_reg[IDX_W-1:0]] <= '{addr: push_addr, data: push_data};
        end
    end

    // Offset gi counts from the oldest entry, so a higher offset is younger.
    logic [SB_DEPTH-1:0] match;
    logic [DATA_W-1:0]   slot_data [SB_DEPTH];

    for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_search
        logic [IDX_W-1:0] slot;
        assign slot          = head_reg[IDX_W-1:0] + IDX_W'(gi);
        assign match[gi]     = (PTR_W'(gi) < count) && (entries[slot].addr == search_addr);
        assign slot_data[gi] = entries[slot].data;
    end

    always_comb begin
        search_hit  = 1'b0;
        search_data = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (match[i]) begin
                search_hit  = 1'b1;
                search_data = slot_data[i];
            end
        end
    end
endmodule

// File: rtl/load_store_pipe.sv
// Load/store unit top: accept logic, fixed-latency in-order load pipe and
// result muxing between forwarded store data and memory read data.
module load_store_pipe
    import lsp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_is_ld,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              in_stall,
    input  logic [CMT_W-1:0]  stores_to_commit,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_valid
);
    logic              accept, ld_acc, st_acc;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    ld_stage_t         stage_in;
    ld_stage_t         pipe_reg [MEM_LAT];
    ld_stage_t         last;

    assign accept = in_valid && !in_stall && !flush;
    assign ld_acc = accept && in_is_ld;
    assign st_acc = accept && !in_is_ld;

    sb_search_queue u_sbq (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .st_push     (st_acc),
        .push_addr   (in_addr),
        .push_data   (in_data),
        .commit_req  (stores_to_commit),
        .search_addr (in_addr),
        .search_hit  (fwd_hit),
        .search_data (fwd_data),
        .full        (in_stall),
        .wr_valid    (mem_wr_valid),
        .wr_addr     (mem_wr_addr),
        .wr_data     (mem_wr_data),
        .wr_ready    (mem_wr_ready)
    );

    assign mem_rd_addr  = in_addr;
    assign mem_rd_valid = ld_acc && !fwd_hit;
    assign stage_in     = '{valid: ld_acc, tag: in_tag, hit: fwd_hit, data: fwd_data};

    // Hits and misses travel the same depth, which keeps results in order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            for (int i = 0; i < MEM_LAT; i++) pipe_reg[i] <= '0;
        end else begin
            pipe_reg[0] <= stage_in;
            for (int i = 1; i < MEM_LAT; i++) pipe_reg[i] <= pipe_reg[i-1];
        end
    end

    assign last      = pipe_reg[MEM_LAT-1];
    assign out_valid = last.valid;
    assign out_tag   = last.valid ? last.tag : '0;
    assign out_data  = !last.valid ? '0 : (last.hit ? last.data : mem_rd_data);
endmodule

// File: tb/tb_load_store_pipe.sv
// Directed bench for load_store_pipe: forwarding, misses, flush, full stall,
// drain backpressure and asynchronous reset.
module tb_load_store_pipe;
    import lsp_pkg::*;

    logic              clk = 1'b0;
    logic              reset, flush, in_valid, in_is_ld;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] in_addr;
    logic [TAG_W-1:0]  in_tag;
    logic              in_stall;
    logic [CMT_W-1:0]  stores_to_commit;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_valid;
    logic [DATA_W-1:0] mem_rd_data;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_valid, mem_wr_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_valid;

    int checks = 0;
    int errors = 0;
    int model_unc = 0;

    always #5 clk = ~clk;

    load_store_pipe dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_is_ld(in_is_ld), .in_data(in_data), .in_addr(in_addr),
        .in_tag(in_tag), .in_stall(in_stall), .stores_to_commit(stores_to_commit),
        .mem_rd_addr(mem_rd_addr), .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_valid(mem_wr_valid),
        .mem_wr_ready(mem_wr_ready), .out_data(out_data), .out_tag(out_tag),
        .out_valid(out_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; also enforce that the bench never over-commits.
    task automatic tick();
        int acc;
        acc = (in_valid && !in_is_ld && !flush && !in_stall && !reset) ? 1 : 0;
        assert (int'(stores_to_commit) <= model_unc)
        else $error("protocol: commit %0d exceeds uncommitted %0d", stores_to_commit, model_unc);
        @(posedge clk);
        model_unc = (reset || flush) ? 0 : model_unc - int'(stores_to_commit) + acc;
        #1;
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; stores_to_commit = 0;
    endtask

    task automatic op(input logic ld, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t);
        in_valid = 1; in_is_ld = ld; in_addr = a; in_data = d; in_tag = t;
        #1;
        $display("op %s addr=%h data=%h tag=%0d stall=%0b rd_valid=%0b",
                 ld ? "LD" : "ST", a, d, t, in_stall, mem_rd_valid);
    endtask

    initial begin
        reset = 1; flush = 0; in_valid = 0; in_is_ld = 0; in_data = 0; in_addr = 0;
        in_tag = 0; stores_to_commit = 0; mem_rd_data = 16'hDEAD; mem_wr_ready = 0;
        @(posedge clk); #1;
        chk("rst_stall", in_stall, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_wr_valid", mem_wr_valid, 0);
        chk("rst_rd_valid", mem_rd_valid, 0);
        chk("rst_out_data", out_data, 0);
        tick(); reset = 0;

        // Store then load to the same address forwards
        op(0, 16'h0010, 16'hBEEF, 3); tick();
        op(1, 16'h0010, 16'h0000, 4);
        chk("fwd_rd_valid", mem_rd_valid, 0); tick();
        idle(); #1; chk("fwd_early", out_valid, 0); tick();
        chk("fwd_valid", out_valid, 1);
        chk("fwd_tag", out_tag, 4);
        chk("fwd_data", out_data, 16'hBEEF);
        flush = 1; tick(); idle(); #1;
        chk("flush_empty_wr", mem_wr_valid, 0);

        // Miss on empty queue reads memory
        op(1, 16'h0020, 16'h0000, 5);
        chk("miss_rd_valid", mem_rd_valid, 1);
        chk("miss_rd_addr", mem_rd_addr, 16'h0020); tick();
        idle(); tick();
        mem_rd_data = 16'h1234; #1;
        chk("miss_valid", out_valid, 1);
        chk("miss_tag", out_tag, 5);
        chk("miss_data", out_data, 16'h1234); tick();
        mem_rd_data = 16'hDEAD;

        // Youngest of two matching stores wins
        op(0, 16'h0030, 16'h0001, 6); tick();
        op(0, 16'h0030, 16'h0002, 7); tick();
        op(1, 16'h0030, 16'h0000, 8);
        chk("young_rd_valid", mem_rd_valid, 0); tick();
        idle(); tick();
        chk("young_tag", out_tag, 8);
        chk("young_data", out_data, 16'h0002);
        flush = 1; tick(); idle();

        // Commit one of three, flush, committed entry drains
        op(0, 16'h0040, 16'h00A0, 1); tick();
        op(0, 16'h0044, 16'h00A1, 2); tick();
        op(0, 16'h0048, 16'h00A2, 3); tick();
        idle(); stores_to_commit = 1; tick();
        idle(); #1;
        chk("cmt_wr_valid", mem_wr_valid, 1);
        chk("cmt_wr_addr", mem_wr_addr, 16'h0040);
        flush = 1; tick(); idle(); #1;
        chk("postflush_wr_valid", mem_wr_valid, 1);
        chk("postflush_wr_data", mem_wr_data, 16'h00A0);
        mem_wr_ready = 1; tick(); #1;
        chk("drained_empty", mem_wr_valid, 0);
        mem_wr_ready = 0;
        op(1, 16'h0044, 16'h0000, 9);
        chk("discard_miss", mem_rd_valid, 1); tick();
        idle(); tick();
        mem_rd_data = 16'h5555; #1;
        chk("discard_data", out_data, 16'h5555); tick();
        mem_rd_data = 16'hDEAD;

        // Commit and flush in the same cycle keeps the committed store
        op(0, 16'h0050, 16'h00B0, 1); tick();
        op(0, 16'h0054, 16'h00B1, 2); tick();
        idle(); stores_to_commit = 1; flush = 1; tick();
        idle(); #1;
        chk("cf_wr_valid", mem_wr_valid, 1);
        chk("cf_wr_addr", mem_wr_addr, 16'h0050);
        mem_wr_ready = 1; tick(); #1;
        chk("cf_drained", mem_wr_valid, 0);
        mem_wr_ready = 0;

        // Fill the queue, then drain two under backpressure
        for (int i = 0; i < SB_DEPTH; i++) begin
            op(0, 16'h0100 + 16'(i), 16'hC000 + 16'(i), 6'(i)); tick();
        end
        idle(); #1;
        chk("full_stall", in_stall, 1);
        op(0, 16'h0200, 16'hFFFF, 20); tick();
        idle(); stores_to_commit = 2; tick();
        idle();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", mem_wr_valid, 1);
            chk("bp_addr", mem_wr_addr, 16'h0100);
            chk("bp_data", mem_wr_data, 16'hC000);
            tick();
        end
        mem_wr_ready = 1; #1;
        chk("drain1_stall", in_stall, 1); tick();
        chk("drain2_stall", in_stall, 0);
        chk("drain2_addr", mem_wr_addr, 16'h0101);
        chk("drain2_data", mem_wr_data, 16'hC001); tick();
        chk("drain_done", mem_wr_valid, 0);
        mem_wr_ready = 0;
        op(1, 16'h0200, 16'h0000, 12);
        chk("dropped_st_miss", mem_rd_valid, 1); tick();
        op(1, 16'h0107, 16'h0000, 13);
        chk("old_st_hit", mem_rd_valid, 0); tick();
        idle(); mem_rd_data = 16'h7777; #1;
        chk("ord1_tag", out_tag, 12);
        chk("ord1_data", out_data, 16'h7777); tick();
        mem_rd_data = 16'hDEAD; #1;
        chk("ord2_tag", out_tag, 13);
        chk("ord2_data", out_data, 16'hC007); tick();

        // Asynchronous reset with a load in flight and committed stores pending
        stores_to_commit = 2; tick(); idle();
        op(1, 16'h0300, 16'h0000, 11); tick();
        idle(); in_addr = 0;
        #2 reset = 1; #1;
        chk("arst_wr_valid", mem_wr_valid, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_stall", in_stall, 0);
        chk("arst_wr_addr", mem_wr_addr, 0);
        tick(); tick(); reset = 0;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_out", out_valid, 0);
            chk("post_rst_wr", mem_wr_valid, 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
